// File: rtl/linear_regression_stream_if.sv
// Sample/result bus of the streaming line fitter.
//   i_x, i_z      signed sample pair (source -> fitter)
//   i_vld, i_last pair valid, final pair of a frame
//   o_rdy         fitter can accept a pair
//   o_theta0/1    signed fixed-point intercept / slope (fitter -> consumer)
//   o_count       number of samples used for the result
//   o_err/sat/ovf degenerate fit / clamped theta / count saturated
//   o_theta_vld   result valid, i_theta_rdy consumer accepts it
// slave modport is the fitter side, master modport is the source/consumer side.
interface linear_regression_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic signed [DATA_WIDTH-1:0] i_x;
  logic signed [DATA_WIDTH-1:0] i_z;
  logic                         i_vld;
  logic                         i_last;
  logic                         o_rdy;
  logic signed [DATA_WIDTH-1:0] o_theta0;
  logic signed [DATA_WIDTH-1:0] o_theta1;
  logic [CNT_WIDTH-1:0]         o_count;
  logic                         o_err;
  logic                         o_sat;
  logic                         o_ovf;
  logic                         o_theta_vld;
  logic                         i_theta_rdy;

  modport slave (
    input  i_x, i_z, i_vld, i_last, i_theta_rdy,
    output o_rdy, o_theta0, o_theta1, o_count, o_err, o_sat, o_ovf, o_theta_vld
  );

  modport master (
    output i_x, i_z, i_vld, i_last, i_theta_rdy,
    input  o_rdy, o_theta0, o_theta1, o_count, o_err, o_sat, o_ovf, o_theta_vld
  );
endinterface

// File: rtl/linear_regression_stream.sv
// Streaming least-squares line fitter. Accumulates n, Sx, Sz, Sxx, Sxz over a
// framed stream of (x, z) pairs, then computes intercept theta0 and slope
// theta1 in Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS using two parallel restoring
// dividers. Fixed latency: result valid DATA_WIDTH+3 cycles after the last
// pair is accepted.
// Ports:
//   i_clock    rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        linear_regression_stream_if.slave (sample in, result out)
module linear_regression_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic                         i_clock,
  input logic                         i_reset_n,
  linear_regression_stream_if.slave   bus
);
  localparam int ACC_W = 2*DATA_WIDTH + CNT_WIDTH;
  // Product width plus headroom so den << (DATA_WIDTH-1) never wraps.
  localparam int W_P   = 2*ACC_W + 2 + DATA_WIDTH;
  localparam int DCW   = $clog2(DATA_WIDTH);

  localparam logic [2:0] ST_ACCUM  = 3'd0;
  localparam logic [2:0] ST_CALC0  = 3'd1;
  localparam logic [2:0] ST_CALC1  = 3'd2;
  localparam logic [2:0] ST_SATCHK = 3'd3;
  localparam logic [2:0] ST_DIV    = 3'd4;
  localparam logic [2:0] ST_OUT    = 3'd5;

  localparam logic [CNT_WIDTH-1:0]        N_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [DCW-1:0]              DIV_LAST = DCW'(DATA_WIDTH-2);
  localparam logic signed [DATA_WIDTH-1:0] TH_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] TH_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Final theta: forced 0 on a degenerate fit, clamped on saturation,
  // otherwise the truncated magnitude with its sign reapplied.
  function automatic logic signed [DATA_WIDTH-1:0] make_theta(
    input logic err, input logic sat, input logic neg,
    input logic [DATA_WIDTH-2:0] quo
  );
    logic signed [DATA_WIDTH-1:0] qv;
    qv = {1'b0, quo};
    if (err)      make_theta = '0;
    else if (sat) make_theta = neg ? TH_MIN : TH_MAX;
    else          make_theta = neg ? -qv : qv;
  endfunction

  logic [2:0]                    state_q, state_d;
  logic                          rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0]          n_q, n_d;
  logic                          ovf_q, ovf_d;
  logic signed [ACC_W-1:0]       sx_q, sx_d, sz_q, sz_d, sxx_q, sxx_d, sxz_q, sxz_d;
  // num*_q hold the numerators, then their magnitudes, then the division remainders.
  logic signed [W_P-1:0]         den_q, den_d, num0_q, num0_d, num1_q, num1_d;
  logic signed [W_P-1:0]         dsh_q, dsh_d;
  logic                          neg0_q, neg0_d, neg1_q, neg1_d;
  logic                          err_q, err_d, sat0_q, sat0_d, sat1_q, sat1_d;
  logic [DATA_WIDTH-2:0]         q0_q, q0_d, q1_q, q1_d;
  logic [DCW-1:0]                dcnt_q, dcnt_d;
  logic signed [DATA_WIDTH-1:0]  th0_q, th0_d, th1_q, th1_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic                          oerr_q, oerr_d, osat_q, osat_d, oovf_q, oovf_d;
  logic                          tvld_q, tvld_d;

  logic                          accept;
  logic signed [ACC_W-1:0]       x_acc, z_acc;
  logic signed [W_P-1:0]         n_ext, sx_ext, sz_ext, sxx_ext, sxz_ext, sh0, sh1;

  assign accept  = bus.i_vld && rdy_q;
  assign x_acc   = ACC_W'(bus.i_x);
  assign z_acc   = ACC_W'(bus.i_z);
  assign n_ext   = W_P'(n_q);
  assign sx_ext  = W_P'(sx_q);
  assign sz_ext  = W_P'(sz_q);
  assign sxx_ext = W_P'(sxx_q);
  assign sxz_ext = W_P'(sxz_q);
  assign sh0     = num0_q <<< FRAC_BITS;
  assign sh1     = num1_q <<< FRAC_BITS;

  // Next-state and datapath logic for all stages.
  always_comb begin
    state_d = state_q; n_d = n_q; ovf_d = ovf_q;
    sx_d = sx_q; sz_d = sz_q; sxx_d = sxx_q; sxz_d = sxz_q;
    den_d = den_q; num0_d = num0_q; num1_d = num1_q; dsh_d = dsh_q;
    neg0_d = neg0_q; neg1_d = neg1_q; err_d = err_q; sat0_d = sat0_q; sat1_d = sat1_q;
    q0_d = q0_q; q1_d = q1_q; dcnt_d = dcnt_q;
    th0_d = th0_q; th1_d = th1_q; cnt_d = cnt_q;
    oerr_d = oerr_q; osat_d = osat_q; oovf_d = oovf_q; tvld_d = tvld_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (n_q == N_MAX) begin
            ovf_d = 1'b1;
          end else begin
            n_d   = n_q + 1'b1;
            sx_d  = sx_q + x_acc;
            sz_d  = sz_q + z_acc;
            sxx_d = sxx_q + x_acc * x_acc;
            sxz_d = sxz_q + x_acc * z_acc;
          end
          if (bus.i_last) state_d = ST_CALC0;
          else            state_d = ST_ACCUM;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_CALC0: begin
        den_d   = n_ext * sxx_ext - sx_ext * sx_ext;
        num1_d  = n_ext * sxz_ext - sx_ext * sz_ext;
        num0_d  = sxx_ext * sz_ext - sx_ext * sxz_ext;
        state_d = ST_CALC1;
      end
      ST_CALC1: begin
        neg0_d  = sh0[W_P-1];
        neg1_d  = sh1[W_P-1];
        num0_d  = sh0[W_P-1] ? -sh0 : sh0;
        num1_d  = sh1[W_P-1] ? -sh1 : sh1;
        state_d = ST_SATCHK;
      end
      ST_SATCHK: begin
        err_d   = (den_q == '0);
        sat0_d  = (den_q != '0) && (num0_q >= (den_q <<< (DATA_WIDTH-1)));
        sat1_d  = (den_q != '0) && (num1_q >= (den_q <<< (DATA_WIDTH-1)));
        // Divisor pre-aligned to the top quotient bit, shifted down each cycle.
        dsh_d   = den_q <<< (DATA_WIDTH-2);
        q0_d    = '0;
        q1_d    = '0;
        dcnt_d  = '0;
        state_d = ST_DIV;
      end
      ST_DIV: begin
        if (num0_q >= dsh_q) begin
          num0_d = num0_q - dsh_q;
          q0_d   = {q0_q[DATA_WIDTH-3:0], 1'b1};
        end else begin
          q0_d   = {q0_q[DATA_WIDTH-3:0], 1'b0};
        end
        if (num1_q >= dsh_q) begin
          num1_d = num1_q - dsh_q;
          q1_d   = {q1_q[DATA_WIDTH-3:0], 1'b1};
        end else begin
          q1_d   = {q1_q[DATA_WIDTH-3:0], 1'b0};
        end
        dsh_d = dsh_q >>> 1;
        if (dcnt_q == DIV_LAST) begin
          state_d = ST_OUT;
        end else begin
          dcnt_d  = dcnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (!tvld_q) begin
          th0_d  = make_theta(err_q, sat0_q, neg0_q, q0_q);
          th1_d  = make_theta(err_q, sat1_q, neg1_q, q1_q);
          cnt_d  = n_q;
          oerr_d = err_q;
          osat_d = !err_q && (sat0_q || sat1_q);
          oovf_d = ovf_q;
          tvld_d = 1'b1;
        end else if (bus.i_theta_rdy) begin
          tvld_d  = 1'b0;
          n_d     = '0;
          ovf_d   = 1'b0;
          sx_d    = '0;
          sz_d    = '0;
          sxx_d   = '0;
          sxz_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          tvld_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
    rdy_d = (state_d == ST_ACCUM);
  end

  // State and datapath registers; reset discards any frame in progress.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_ACCUM; rdy_q <= 1'b0; n_q <= '0; ovf_q <= 1'b0;
      sx_q <= '0; sz_q <= '0; sxx_q <= '0; sxz_q <= '0;
      den_q <= '0; num0_q <= '0; num1_q <= '0; dsh_q <= '0;
      neg0_q <= 1'b0; neg1_q <= 1'b0; err_q <= 1'b0; sat0_q <= 1'b0; sat1_q <= 1'b0;
      q0_q <= '0; q1_q <= '0; dcnt_q <= '0;
      th0_q <= '0; th1_q <= '0; cnt_q <= '0;
      oerr_q <= 1'b0; osat_q <= 1'b0; oovf_q <= 1'b0; tvld_q <= 1'b0;
    end else begin
      state_q <= state_d; rdy_q <= rdy_d; n_q <= n_d; ovf_q <= ovf_d;
      sx_q <= sx_d; sz_q <= sz_d; sxx_q <= sxx_d; sxz_q <= sxz_d;
      den_q <= den_d; num0_q <= num0_d; num1_q <= num1_d; dsh_q <= dsh_d;
      neg0_q <= neg0_d; neg1_q <= neg1_d; err_q <= err_d; sat0_q <= sat0_d; sat1_q <= sat1_d;
      q0_q <= q0_d; q1_q <= q1_d; dcnt_q <= dcnt_d;
      th0_q <= th0_d; th1_q <= th1_d; cnt_q <= cnt_d;
      oerr_q <= oerr_d; osat_q <= osat_d; oovf_q <= oovf_d; tvld_q <= tvld_d;
    end
  end

  assign bus.o_rdy       = rdy_q;
  assign bus.o_theta0    = th0_q;
  assign bus.o_theta1    = th1_q;
  assign bus.o_count     = cnt_q;
  assign bus.o_err       = oerr_q;
  assign bus.o_sat       = osat_q;
  assign bus.o_ovf       = oovf_q;
  assign bus.o_theta_vld = tvld_q;
endmodule

// File: tb/tb_linear_regression_stream.sv
module tb_linear_regression_stream;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   accept_cyc = 0;

  linear_regression_stream_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

  linear_regression_stream #(
    .DATA_WIDTH(32), .FRAC_BITS(8), .CNT_WIDTH(16)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic send_pair(input int x, input int z, input bit last);
    int guard;
    guard = 0;
    bus.i_x = x; bus.i_z = z; bus.i_vld = 1'b1; bus.i_last = last;
    while (!bus.o_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    bus.i_vld = 1'b0; bus.i_last = 1'b0;
  endtask

  task automatic wait_vld(output int lat);
    int guard;
    guard = 0;
    while (!bus.o_theta_vld && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("vld_timeout", 32'd0, 32'd1);
    lat = cyc - accept_cyc;
  endtask

  task automatic check_result(input string tag, input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] cnt, input bit err, input bit sat, input bit ovf);
    check_eq({tag, "_theta0"}, bus.o_theta0, t0);
    check_eq({tag, "_theta1"}, bus.o_theta1, t1);
    check_eq({tag, "_count"},  {16'd0, bus.o_count}, cnt);
    check_eq({tag, "_err"},    {31'd0, bus.o_err}, {31'd0, err});
    check_eq({tag, "_sat"},    {31'd0, bus.o_sat}, {31'd0, sat});
    check_eq({tag, "_ovf"},    {31'd0, bus.o_ovf}, {31'd0, ovf});
  endtask

  task automatic consume(input string tag);
    bus.i_theta_rdy = 1'b1;
    @(negedge clk);
    bus.i_theta_rdy = 1'b0;
    check_eq({tag, "_vld_drop"}, {31'd0, bus.o_theta_vld}, 32'd0);
    check_eq({tag, "_rdy_back"}, {31'd0, bus.o_rdy}, 32'd1);
  endtask

  task automatic frame1();
    send_pair(1, 3, 1'b0);
    send_pair(2, 5, 1'b0);
    send_pair(3, 7, 1'b0);
    send_pair(4, 9, 1'b1);
  endtask

  initial begin
    int lat;
    logic [31:0] h0, h1;
    bit stable;
    rst_n = 1'b0;
    bus.i_x = '0; bus.i_z = '0; bus.i_vld = 1'b0; bus.i_last = 1'b0; bus.i_theta_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", {31'd0, bus.o_rdy}, 32'd0);
    check_eq("rst_vld", {31'd0, bus.o_theta_vld}, 32'd0);
    check_result("rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_rdy", {31'd0, bus.o_rdy}, 32'd1);

    // Basic fit z = 2x + 1 and fixed latency.
    frame1();
    check_eq("f1_rdy_busy", {31'd0, bus.o_rdy}, 32'd0);
    wait_vld(lat);
    check_eq("f1_latency", lat, 32'd35);
    check_result("f1", 32'd256, 32'd512, 32'd4, 1'b0, 1'b0, 1'b0);
    consume("f1");

    // Negative slope.
    send_pair(0, 6, 1'b0);
    send_pair(1, 4, 1'b0);
    send_pair(2, 2, 1'b1);
    wait_vld(lat);
    check_result("neg", 32'd1536, 32'hFFFFFE00, 32'd3, 1'b0, 1'b0, 1'b0);
    consume("neg");

    // Truncation toward zero; i_last without i_vld must be ignored.
    send_pair(0, 0, 1'b0);
    bus.i_last = 1'b1;
    @(negedge clk);
    bus.i_last = 1'b0;
    send_pair(1, 1, 1'b0);
    send_pair(2, 1, 1'b0);
    send_pair(3, 2, 1'b1);
    wait_vld(lat);
    check_result("trunc", 32'd25, 32'd153, 32'd4, 1'b0, 1'b0, 1'b0);
    consume("trunc");

    // Vertical line: zero denominator, same latency.
    send_pair(5, 1, 1'b0);
    send_pair(5, 2, 1'b0);
    send_pair(5, 3, 1'b1);
    wait_vld(lat);
    check_eq("degen_latency", lat, 32'd35);
    check_result("degen", 32'd0, 32'd0, 32'd3, 1'b1, 1'b0, 1'b0);
    consume("degen");

    // One-sample frame.
    send_pair(7, 7, 1'b1);
    wait_vld(lat);
    check_result("single", 32'd0, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);
    consume("single");

    // Slope 2^30 overflows Q24.8 and clamps; intercept is exactly 0.
    send_pair(0, 0, 1'b0);
    send_pair(1, 32'sd1073741824, 1'b1);
    wait_vld(lat);
    check_result("sat", 32'd0, 32'h7FFFFFFF, 32'd2, 1'b0, 1'b1, 1'b0);
    consume("sat");

    // Backpressure: hold the result for 10 cycles, then a back-to-back frame.
    frame1();
    wait_vld(lat);
    h0 = bus.o_theta0;
    h1 = bus.o_theta1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_theta0 !== h0 || bus.o_theta1 !== h1 || bus.o_theta_vld !== 1'b1 ||
          bus.o_rdy !== 1'b0 || bus.o_count !== 16'd4)
        stable = 1'b0;
    end
    check_eq("bp_stable", {31'd0, stable}, 32'd1);
    check_result("bp", 32'd256, 32'd512, 32'd4, 1'b0, 1'b0, 1'b0);
    consume("bp");
    send_pair(0, 6, 1'b0);
    send_pair(1, 4, 1'b0);
    send_pair(2, 2, 1'b1);
    wait_vld(lat);
    check_result("b2b", 32'd1536, 32'hFFFFFE00, 32'd3, 1'b0, 1'b0, 1'b0);
    consume("b2b");

    // Reset in the middle of DIV discards the frame and clears outputs.
    send_pair(9, 1, 1'b0);
    send_pair(3, 8, 1'b1);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_rdy", {31'd0, bus.o_rdy}, 32'd0);
    check_eq("mrst_vld", {31'd0, bus.o_theta_vld}, 32'd0);
    check_result("mrst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mrst_rel_rdy", {31'd0, bus.o_rdy}, 32'd1);
    frame1();
    wait_vld(lat);
    check_eq("rerun_latency", lat, 32'd35);
    check_result("rerun", 32'd256, 32'd512, 32'd4, 1'b0, 1'b0, 1'b0);
    consume("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
